// File: rtl/ts_stream_generator.sv
// Multi-channel MPEG-2 TS packet source: per-channel PID/CC, optional CC-skip (lost packet) injection.
// Latency: first byte GAP_CYCLES+1 cycles after start, then one byte every GAP_CYCLES+1 cycles; no backpressure, stop aborts.
module ts_stream_generator #(
    parameter int          NUM_CH      = 4,
    parameter int          PKT_LEN     = 188,
    parameter int          GAP_CYCLES  = 1,
    parameter logic [12:0] BASE_PID    = 13'h0100,
    parameter int          LOSS_PERIOD = 4,
    parameter int          NUM_PKTS    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic                loss_en,
    output logic [NUM_CH-1:0]   valid,
    output logic [8*NUM_CH-1:0] byte_data,
    output logic                sop,
    output logic                eop,
    output logic                busy,
    output logic                done
);
    localparam int IW  = $clog2(PKT_LEN);
    localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int LPS = (LOSS_PERIOD > 0) ? LOSS_PERIOD : 1;
    localparam int LW  = (LPS > 1) ? $clog2(LPS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_GAP, S_BYTE, S_DONE} state_t;

    state_t              state_q;
    logic [GW-1:0]       gap_cnt_q;
    logic [IW-1:0]       idx_q;
    logic [31:0]         pkt_cnt_q;
    logic [3:0]          cc_q   [NUM_CH];
    logic [LW-1:0]       lmod_q [NUM_CH];
    logic [NUM_CH-1:0]   valid_q;
    logic [8*NUM_CH-1:0] data_q;
    logic                sop_q, eop_q, busy_q, done_q;

    logic                restart, abort, gap_end, last_pkt, emit, is_eop;
    logic [IW-1:0]       idx_cur;
    logic [12:0]         pid;
    logic [8*NUM_CH-1:0] data_d;
    logic [3:0]          cc_d   [NUM_CH];
    logic [LW-1:0]       lmod_d [NUM_CH];

    always_comb begin
        restart  = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
        abort    = stop && (state_q != S_IDLE);
        gap_end  = (state_q == S_GAP) && (gap_cnt_q == GW'(GAP_CYCLES - 1));
        last_pkt = (NUM_PKTS > 0) && (pkt_cnt_q == 32'(NUM_PKTS));
        // With no gap the byte is emitted on the same edge that enters or stays in BYTE
        emit     = !abort && (gap_end ||
                   ((GAP_CYCLES == 0) && (restart || ((state_q == S_BYTE) && !last_pkt))));
        idx_cur  = restart ? '0 : idx_q;
        is_eop   = (idx_cur == IW'(PKT_LEN - 1));
        data_d   = '0;
        pid      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pid = BASE_PID + 13'(i);
            if (idx_cur == IW'(0))      data_d[8*i +: 8] = 8'h47;
            else if (idx_cur == IW'(1)) data_d[8*i +: 8] = {3'b000, pid[12:8]};
            else if (idx_cur == IW'(2)) data_d[8*i +: 8] = pid[7:0];
            else if (idx_cur == IW'(3)) data_d[8*i +: 8] = {4'b0001, cc_q[i]};
            else                        data_d[8*i +: 8] = 8'(idx_cur) + 8'(i);
            cc_d[i]   = cc_q[i] + ((loss_en && (LOSS_PERIOD > 0) && (lmod_q[i] == LW'(LPS - 1))) ? 4'd2 : 4'd1);
            lmod_d[i] = (lmod_q[i] == LW'(LPS - 1)) ? '0 : lmod_q[i] + LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gap_cnt_q <= '0;
            idx_q     <= '0;
            pkt_cnt_q <= '0;
            valid_q   <= '0;
            data_q    <= '0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cc_q[i]   <= '0;
                lmod_q[i] <= LW'(i % LPS);
            end
        end else if (abort) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (restart) begin
                        state_q   <= (GAP_CYCLES > 0) ? S_GAP : S_BYTE;
                        gap_cnt_q <= '0;
                        idx_q     <= '0;
                        pkt_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            cc_q[i]   <= '0;
                            lmod_q[i] <= LW'(i % LPS);
                        end
                    end
                end
                S_GAP: begin
                    if (gap_end) state_q <= S_BYTE;
                    else         gap_cnt_q <= gap_cnt_q + GW'(1);
                end
                S_BYTE: begin
                    if (last_pkt) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (GAP_CYCLES > 0) begin
                        state_q   <= S_GAP;
                        gap_cnt_q <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (emit) begin
                valid_q <= '1;
                data_q  <= data_d;
                sop_q   <= (idx_cur == '0);
                eop_q   <= is_eop;
                idx_q   <= is_eop ? '0 : idx_cur + IW'(1);
                if (is_eop) begin
                    pkt_cnt_q <= pkt_cnt_q + 32'd1;
                    for (int i = 0; i < NUM_CH; i++) begin
                        cc_q[i]   <= cc_d[i];
                        lmod_q[i] <= lmod_d[i];
                    end
                end
            end
        end
    end

    assign valid     = valid_q;
    assign byte_data = data_q;
    assign sop       = sop_q;
    assign eop       = eop_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_ts_stream_generator.sv
// Bench for ts_stream_generator: four parameterisations share one stimulus, each checked every cycle
// against a packet-level model, plus literal expectations for header bytes, CC sequences and cadence.
module tb_ts_stream_generator;
    localparam int NI  = 4;
    localparam int NCH = 4;
    localparam int PL  = 188;
    localparam int          GAP_C [NI] = '{1, 0, 2, 1};
    localparam int          PKT_C [NI] = '{2, 1, 6, 0};
    localparam int          LP_C  [NI] = '{4, 4, 4, 0};
    localparam logic [12:0] PID_C [NI] = '{13'h0100, 13'h1FFE, 13'h0100, 13'h0ABC};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic loss_en = 1'b0;

    logic [NCH-1:0]   valid_w [NI];
    logic [8*NCH-1:0] data_w  [NI];
    logic             sop_w   [NI];
    logic             eop_w   [NI];
    logic             busy_w  [NI];
    logic             done_w  [NI];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_byte(input int k, input int ch, input int cc, input logic [12:0] base);
        logic [12:0] pid;
        pid = base + 13'(ch);
        case (k)
            0:       return 8'h47;
            1:       return {3'b000, pid[12:8]};
            2:       return pid[7:0];
            3:       return {4'b0001, 4'(cc)};
            default: return 8'((k + ch) % 256);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int          GAP    = GAP_C[g];
        localparam int          NP     = PKT_C[g];
        localparam int          LP     = LP_C[g];
        localparam int          LPS    = (LP > 0) ? LP : 1;
        localparam logic [12:0] PID    = PID_C[g];
        localparam int          T_LAST = GAP + (NP * PL - 1) * (GAP + 1);

        ts_stream_generator #(
            .NUM_CH(NCH), .PKT_LEN(PL), .GAP_CYCLES(GAP), .BASE_PID(PID),
            .LOSS_PERIOD(LP), .NUM_PKTS(NP)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loss_en(loss_en),
            .valid(valid_w[g]), .byte_data(data_w[g]), .sop(sop_w[g]), .eop(eop_w[g]),
            .busy(busy_w[g]), .done(done_w[g])
        );

        // Model: 0 idle, 1 running, 2 done; m_t counts edges since the start edge
        int m_state = 0;
        int m_t = 0;
        int m_n, m_k, m_p;
        int m_cc [NCH];
        logic e_valid = 1'b0, e_sop = 1'b0, e_eop = 1'b0;
        logic [8*NCH-1:0] e_data = '0;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_state = 0; m_t = 0;
                e_valid = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_data = '0;
                for (int i = 0; i < NCH; i++) m_cc[i] = 0;
            end else begin
                e_valid = 1'b0; e_sop = 1'b0; e_eop = 1'b0;
                if (m_state != 0 && stop) m_state = 0;
                else if (m_state != 1 && start) begin
                    m_state = 1; m_t = 0;
                    for (int i = 0; i < NCH; i++) m_cc[i] = 0;
                end else if (m_state == 1) m_t++;
                if (m_state == 1) begin
                    if (NP > 0 && m_t > T_LAST) m_state = 2;
                    else if (m_t >= GAP && (m_t - GAP) % (GAP + 1) == 0) begin
                        m_n = (m_t - GAP) / (GAP + 1);
                        m_p = m_n / PL;
                        m_k = m_n % PL;
                        e_valid = 1'b1;
                        e_sop = (m_k == 0);
                        e_eop = (m_k == PL - 1);
                        for (int i = 0; i < NCH; i++) e_data[8*i +: 8] = exp_byte(m_k, i, m_cc[i], PID);
                        if (m_k == PL - 1)
                            for (int i = 0; i < NCH; i++)
                                m_cc[i] = (m_cc[i] + ((loss_en && LP > 0 && (i + m_p) % LPS == LPS - 1) ? 2 : 1)) % 16;
                    end
                end
            end
        end

        always @(negedge clk)
            chk($sformatf("inst%0d_outputs", g),
                {valid_w[g], sop_w[g], eop_w[g], busy_w[g], done_w[g], data_w[g]},
                {{NCH{e_valid}}, e_sop, e_eop, m_state == 1, m_state == 2, e_data});
    end

    initial begin
        int nval [NI];
        int firstv [NI];
        logic [7:0] b0 [$];
        logic [7:0] q0 [$];
        logic [7:0] q3 [$];
        logic [3:0] cc0 [$];
        logic [3:0] cc3 [$];
        logic [7:0] exp_hdr [6];
        logic [3:0] exp_cc0 [6];
        logic [3:0] exp_cc3 [6];
        int run1, maxrun1, eop_idx0, strobes0, b2c3, b4c2, n;

        exp_hdr = '{8'h47, 8'h01, 8'h00, 8'h10, 8'h04, 8'h05};
        exp_cc0 = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6};
        exp_cc3 = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            chk("reset_outputs", {valid_w[i], sop_w[i], eop_w[i], busy_w[i], done_w[i], data_w[i]}, 64'd0);

        // Directed run: header content, cadence, burst length, loss-injected CC sequences
        loss_en = 1'b1;
        start = 1'b1;
        for (int i = 0; i < NI; i++) begin nval[i] = 0; firstv[i] = -1; end
        run1 = 0; maxrun1 = 0; eop_idx0 = -1; strobes0 = -1; b2c3 = -1; b4c2 = -1;
        for (int c = 1; c <= 4000 && !done_w[2]; c++) begin
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < NI; i++)
                if (valid_w[i][0]) begin
                    if (nval[i] == 0) firstv[i] = c;
                    nval[i]++;
                end
            if (valid_w[0][0]) begin
                b0.push_back(data_w[0][7:0]);
                if (eop_w[0] && eop_idx0 < 0) eop_idx0 = nval[0] - 1;
                if (nval[0] == 3) b2c3 = int'(data_w[0][31:24]);
                if (nval[0] == 5) b4c2 = int'(data_w[0][23:16]);
            end
            if (done_w[0] && strobes0 < 0) strobes0 = nval[0];
            run1 = valid_w[1][0] ? run1 + 1 : 0;
            if (run1 > maxrun1) maxrun1 = run1;
            if (valid_w[2][0] && (nval[2] - 1) % PL == 3) begin
                cc0.push_back(data_w[2][3:0]);
                cc3.push_back(data_w[2][27:24]);
            end
        end
        chk("run_completed", done_w[2], 1);
        chk("first_valid_gap1", firstv[0], 2);
        chk("first_valid_gap0", firstv[1], 1);
        chk("first_valid_gap2", firstv[2], 3);
        chk("ch0_byte_count", b0.size(), 2 * PL);
        if (b0.size() >= PL + 4) begin
            for (int j = 0; j < 6; j++) chk($sformatf("ch0_byte%0d", j), b0[j], exp_hdr[j]);
            chk("pkt2_cc_byte", b0[PL + 3], 8'h11);
        end
        chk("eop_index", eop_idx0, PL - 1);
        chk("strobes_to_done", strobes0, 2 * PL);
        chk("gap0_burst_len", maxrun1, PL);
        chk("gap0_done_idle", {done_w[1], valid_w[1]}, 5'b10000);
        chk("ch3_byte2", b2c3, 8'h03);
        chk("ch2_byte4", b4c2, 8'h06);
        chk("cc_pkt_count", cc0.size(), 6);
        if (cc0.size() == 6)
            for (int j = 0; j < 6; j++) begin
                chk($sformatf("loss_cc_ch0_pkt%0d", j), cc0[j], exp_cc0[j]);
                chk($sformatf("loss_cc_ch3_pkt%0d", j), cc3[j], exp_cc3[j]);
            end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;

        // Abort on byte 50, then restart must begin cleanly with CC cleared
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 400 && n < 51; c++) begin
            @(negedge clk);
            if (valid_w[0][0]) n++;
            if (valid_w[3][0] && q3.size() < 4) q3.push_back(data_w[3][7:0]);
        end
        chk("abort_reached_byte50", n, 51);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("abort_outputs", {valid_w[0], valid_w[1], busy_w[0], busy_w[1], done_w[0]}, 64'd0);
        chk("cc_cleared_on_start", (q3.size() == 4) ? q3[3] : 8'hFF, 8'h10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20 && q0.size() < 4; c++) begin
            @(negedge clk);
            if (valid_w[0][0]) q0.push_back(data_w[0][7:0]);
        end
        chk("restart_byte0", (q0.size() == 4) ? q0[0] : 8'h00, 8'h47);
        chk("restart_cc", (q0.size() == 4) ? q0[3] : 8'h00, 8'h10);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;

        // Asynchronous reset between edges, mid-packet
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++)
            chk("async_reset_outputs", {valid_w[i], sop_w[i], eop_w[i], busy_w[i], done_w[i], data_w[i]}, 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (400) @(negedge clk);

        // Randomised control traffic, checked cycle by cycle against the model
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 99) == 0);
            stop  = ($urandom_range(0, 3999) == 0);
            if ($urandom_range(0, 29) == 0) loss_en = ~loss_en;
            if ($urandom_range(0, 4999) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
